frame_point_sequencer: RTL
==========================

FRAME_POINT_SEQUENCER -- requirements
Module: frame_point_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, point-memory address width.
REQ-002 SHALL have parameter COORD_W, default 12, DAC coordinate width.
REQ-003 SHALL have port clk  in  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port start  in  1  single-cycle frame-start pulse, already synchronised to clk.
REQ-006 SHALL have port num_points  in  ADDR_W  points in frame; sampled on accepted start.
REQ-007 SHALL have port dwell_cycles  in  16  hold cycles per point; sampled on accepted start.
REQ-008 SHALL have port mem_addr  out  ADDR_W  point-memory read address.
REQ-009 SHALL have port mem_en  out  1  read strobe.
REQ-010 SHALL have port mem_rdata  in  2*COORD_W+1  {laser_on, y, x}; valid one cycle after mem_en.
REQ-011 SHALL have ports dac_x, dac_y  out  COORD_W each  registered coordinates.
REQ-012 SHALL have port laser_en  out  1  laser gate.
REQ-013 SHALL have ports dac_valid out 1 / dac_ready in 1  DAC handshake.
REQ-014 SHALL have ports busy out 1 (frame in progress) and frame_done out 1 (one-cycle pulse).

Function
REQ-015 SHALL implement states IDLE, FETCH, WAIT_MEM, PRESENT, DWELL, DONE.
- IDLE, start=1, num_points!=0: -> FETCH, index=0, busy=1.
- IDLE, start=1, num_points=0: -> DONE; no memory read, no DAC transaction.
- FETCH: mem_en=1, mem_addr=index for exactly one cycle -> WAIT_MEM.
- WAIT_MEM: capture mem_rdata into dac_x/dac_y/laser_en -> PRESENT.
- PRESENT: dac_valid=1, outputs stable until dac_valid&dac_ready edge -> DWELL (dwell_cycles>0) else next point.
- DWELL: counter counts dwell_cycles cycles, outputs held -> next point.
- Next point: index+1 < num_points -> FETCH; else -> DONE.
- DONE: frame_done=1 one cycle, laser_en forced 0, busy=0 -> IDLE.
REQ-016 SHALL raise dac_valid on the third rising edge after the edge that samples start.
REQ-017 SHALL never change dac_x/dac_y/laser_en while dac_valid=1 and dac_ready=0.
REQ-018 SHALL hold dac_x/dac_y at the last point after DONE; the galvo is not re-centred.
REQ-019 SHALL keep index width ADDR_W; num_points=2^ADDR_W-1 is the maximum and shall not wrap.
REQ-020 SHALL ignore start outside IDLE, unless PENDING_START_EN is defined.
REQ-021 SHALL use the latched num_points/dwell_cycles for the whole frame; mid-frame input changes have no effect.

Reset
REQ-022 SHALL on reset go to IDLE; busy, frame_done, dac_valid, mem_en, laser_en, dac_x, dac_y, mem_addr, index and counter all 0.
REQ-023 SHALL abort any frame immediately on reset, with no frame_done pulse and laser_en=0 on the next cycle.

Configuration
REQ-024 SHALL support macro PENDING_START_EN.
- Defined: start while busy sets a one-deep pending flag, and DONE goes to FETCH for a new frame; frame_done still pulses. Further starts while pending are dropped. Reset clears the flag.
- Undefined: start outside IDLE is discarded; no pending flag is synthesised.

Structure
REQ-025 SHALL take the state enum and the mem_rdata field offsets (X_LSB, Y_LSB, LASER_BIT) from shared package laser_pkg.
REQ-026 SHALL place the dwell counter in sub-module dwell_timer, with inputs load/value and output expired.

Verification
REQ-027 Start, num_points=3, dwell=4, dac_ready=1: three transactions at points 0,1,2; dac_valid high at edge 3 after start; frame_done one cycle after last dwell.
REQ-028 dac_ready held 0 for 10 cycles in PRESENT: dac_valid stays 1 and dac_x/dac_y/laser_en stay stable; the transaction completes on the first ready edge.
REQ-029 Start with num_points=0: frame_done pulses next cycle; mem_en and dac_valid never assert.
REQ-030 Start during frame, dwell=0: macro undefined -> ignored; macro defined -> second frame starts directly from DONE.
REQ-031 Reset asserted in DWELL of point 1: next cycle all outputs 0, state IDLE, no frame_done.
REQ-032 Point with laser_on=1 as final point: laser_en=1 during its PRESENT/DWELL, 0 from DONE onward; dac_x/dac_y retain its values.

Source files
------------

// File: rtl/laser_pkg.sv
// laser_pkg: shared types and constants for the laser frame sequencer.
//   state_t   - sequencer FSM states.
//   X_LSB, Y_LSB, LASER_BIT - position of each mem_rdata field {laser_on, y, x},
//               in units of COORD_W, so the same package serves any coordinate
//               width (bit offset = slot * COORD_W).
package laser_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_MEM,
    PRESENT,
    DWELL,
    DONE
  } state_t;

  localparam int X_LSB     = 0;
  localparam int Y_LSB     = 1;
  localparam int LASER_BIT = 2;

endpackage

// File: rtl/dwell_timer.sv
// dwell_timer: per-point hold counter.
//   clk, reset - rising-edge clock, synchronous active-high reset
//   load       - load the counter with value
//   value      - number of cycles to hold (must be non-zero when loaded)
//   expired    - high in the final cycle of the hold period
module dwell_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] value,
  output logic        expired
);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = value;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // A load of N gives N cycles with the counter at N..1; the last one is expired.
  assign expired = (cnt_q <= 16'd1);

endmodule

// File: rtl/frame_point_sequencer.sv
// frame_point_sequencer: walks a frame of points from point memory and
// presents each to the galvo DAC with a valid/ready handshake, then holds it
// for a programmable dwell.
//   clk, reset          - rising-edge clock, synchronous active-high reset
//   start               - one-cycle frame start; num_points/dwell_cycles latched with it
//   mem_addr, mem_en    - point-memory read port; mem_rdata valid one cycle after mem_en
//   dac_x, dac_y        - registered coordinates, laser_en - laser gate
//   dac_valid/dac_ready - DAC handshake
//   busy, frame_done    - frame in progress / one-cycle end-of-frame pulse
// Build option: PENDING_START_EN - a start while busy is queued (one deep)
// and launched from DONE instead of being dropped.
module frame_point_sequencer
  import laser_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int COORD_W = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    num_points,
  input  logic [15:0]          dwell_cycles,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic                 mem_en,
  input  logic [2*COORD_W:0]   mem_rdata,
  output logic [COORD_W-1:0]   dac_x,
  output logic [COORD_W-1:0]   dac_y,
  output logic                 laser_en,
  output logic                 dac_valid,
  input  logic                 dac_ready,
  output logic                 busy,
  output logic                 frame_done
);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   index_q, index_d;
  logic [ADDR_W-1:0]   num_q, num_d;
  logic [15:0]         dwell_q, dwell_d;
  logic [COORD_W-1:0]  dac_x_q, dac_x_d;
  logic [COORD_W-1:0]  dac_y_q, dac_y_d;
  logic                laser_q, laser_d;
  logic                dac_valid_q, dac_valid_d;

  logic                launch, advance, timer_load, timer_expired;
  logic [ADDR_W-1:0]   launch_num;
  logic [15:0]         launch_dwell;
  logic [ADDR_W:0]     index_inc;

`ifdef PENDING_START_EN
  logic                pending_q, pending_d;
  logic [ADDR_W-1:0]   pend_num_q, pend_num_d;
  logic [15:0]         pend_dwell_q, pend_dwell_d;
`endif

  // One extra bit so the last-point test cannot wrap at num_points = 2^ADDR_W-1.
  assign index_inc = {1'b0, index_q} + {{ADDR_W{1'b0}}, 1'b1};

  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    num_d        = num_q;
    dwell_d      = dwell_q;
    dac_x_d      = dac_x_q;
    dac_y_d      = dac_y_q;
    laser_d      = laser_q;
    dac_valid_d  = dac_valid_q;
    launch       = 1'b0;
    launch_num   = num_points;
    launch_dwell = dwell_cycles;
    advance      = 1'b0;
    timer_load   = 1'b0;
`ifdef PENDING_START_EN
    pending_d    = pending_q;
    pend_num_d   = pend_num_q;
    pend_dwell_d = pend_dwell_q;
    if (start && (state_q != IDLE) && !pending_q) begin
      pending_d    = 1'b1;
      pend_num_d   = num_points;
      pend_dwell_d = dwell_cycles;
    end
`endif

    case (state_q)
      IDLE: begin
`ifdef PENDING_START_EN
        // A start that arrived during DONE is launched here.
        if (pending_q) begin
          launch       = 1'b1;
          launch_num   = pend_num_q;
          launch_dwell = pend_dwell_q;
          pending_d    = 1'b0;
        end else
`endif
        if (start) launch = 1'b1;
      end
      FETCH:    state_d = WAIT_MEM;
      WAIT_MEM: begin
        dac_x_d = mem_rdata[X_LSB*COORD_W +: COORD_W];
        dac_y_d = mem_rdata[Y_LSB*COORD_W +: COORD_W];
        laser_d = mem_rdata[LASER_BIT*COORD_W];
        state_d = PRESENT;
      end
      PRESENT: begin
        // First PRESENT cycle raises the registered valid; hand off on ready.
        if (!dac_valid_q) begin
          dac_valid_d = 1'b1;
        end else if (dac_ready) begin
          dac_valid_d = 1'b0;
          if (dwell_q != '0) begin
            timer_load = 1'b1;
            state_d    = DWELL;
          end else begin
            advance = 1'b1;
          end
        end
      end
      DWELL: if (timer_expired) advance = 1'b1;
      DONE: begin
        state_d = IDLE;
`ifdef PENDING_START_EN
        if (pending_q) begin
          launch       = 1'b1;
          launch_num   = pend_num_q;
          launch_dwell = pend_dwell_q;
          pending_d    = 1'b0;
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    if (launch) begin
      num_d   = launch_num;
      dwell_d = launch_dwell;
      index_d = '0;
      state_d = (launch_num == '0) ? DONE : FETCH;
    end

    if (advance) begin
      if (index_inc < {1'b0, num_q}) begin
        index_d = index_inc[ADDR_W-1:0];
        state_d = FETCH;
      end else begin
        laser_d = 1'b0;
        state_d = DONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      index_q     <= '0;
      num_q       <= '0;
      dwell_q     <= '0;
      dac_x_q     <= '0;
      dac_y_q     <= '0;
      laser_q     <= 1'b0;
      dac_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      num_q       <= num_d;
      dwell_q     <= dwell_d;
      dac_x_q     <= dac_x_d;
      dac_y_q     <= dac_y_d;
      laser_q     <= laser_d;
      dac_valid_q <= dac_valid_d;
    end
  end

`ifdef PENDING_START_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q    <= 1'b0;
      pend_num_q   <= '0;
      pend_dwell_q <= '0;
    end else begin
      pending_q    <= pending_d;
      pend_num_q   <= pend_num_d;
      pend_dwell_q <= pend_dwell_d;
    end
  end
`endif

  dwell_timer u_dwell_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (timer_load),
    .value   (dwell_q),
    .expired (timer_expired)
  );

  assign mem_addr   = index_q;
  assign mem_en     = (state_q == FETCH);
  assign dac_x      = dac_x_q;
  assign dac_y      = dac_y_q;
  assign laser_en   = laser_q;
  assign dac_valid  = dac_valid_q;
  assign busy       = (state_q != IDLE) && (state_q != DONE);
  assign frame_done = (state_q == DONE);

endmodule
